// File: rtl/weapons_pkg.sv
// Shared weapon-subsystem definitions: round-count width, ammo loader states
// and the attack-mode code.
package weapons_pkg;

  localparam int AMMO_W_DEF = 9;

  localparam logic [3:0] ATTACK_MODE_CODE = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/ammo_loader_if.sv
// Weapon <-> ammo loader bus: reload request, magazine parameters, depot
// stock loading and the loader status/ammo load outputs.
interface ammo_loader_if #(
  parameter int AMMO_W = weapons_pkg::AMMO_W_DEF
);
  logic              reload_req;
  logic              fire_active;
  logic [AMMO_W-1:0] cur_ammo;
  logic [AMMO_W-1:0] max_ammo;
  logic [AMMO_W-1:0] xfer_rate;
  logic              depot_load;
  logic [AMMO_W-1:0] depot_in;
  logic [AMMO_W-1:0] ammo_out;
  logic              loading;
  logic              busy;
  logic              done;
  logic [AMMO_W-1:0] depot_level;
  logic              error;

  modport master (
    output reload_req, fire_active, cur_ammo, max_ammo, xfer_rate,
           depot_load, depot_in,
    input  ammo_out, loading, busy, done, depot_level, error
  );

  modport slave (
    input  reload_req, fire_active, cur_ammo, max_ammo, xfer_rate,
           depot_load, depot_in,
    output ammo_out, loading, busy, done, depot_level, error
  );
endinterface

// File: rtl/depot_counter.sv
// Depot stock register: overwrite on load, otherwise subtract the transferred
// chunk. Callers never request both in the same cycle.
module depot_counter #(
  parameter int AMMO_W = weapons_pkg::AMMO_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [AMMO_W-1:0] load_val,
  input  logic              sub,
  input  logic [AMMO_W-1:0] sub_val,
  output logic [AMMO_W-1:0] level
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else if (load) begin
      level <= load_val;
    end else if (sub) begin
      level <= level - sub_val;
    end
  end

endmodule

// File: rtl/ammo_loader.sv
// Ammo loader: refills the weapon magazine from the depot in rate-limited
// chunks. Define AMMO_LOADER_AUTO_EN to also start a reload on an empty idle magazine.
module ammo_loader
  import weapons_pkg::*;
#(
  parameter int AMMO_W = AMMO_W_DEF
) (
  input logic         clk,
  input logic         rst,
  ammo_loader_if.slave bus
);

  loader_state_e     state_q, state_d;
  logic [AMMO_W-1:0] acc_q;
  logic [AMMO_W-1:0] ammo_out_q;
  logic              loading_q;
  logic [AMMO_W-1:0] depot_level;
  logic [AMMO_W-1:0] rate_eff, room, chunk, new_acc, new_depot;
  logic              start, xfer_go, depot_wr;

  function automatic logic [AMMO_W-1:0] min3(input logic [AMMO_W-1:0] a,
                                             input logic [AMMO_W-1:0] b,
                                             input logic [AMMO_W-1:0] c);
    logic [AMMO_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  // Chunk never exceeds remaining room or depot stock, so neither side wraps
  always_comb begin
    rate_eff  = (bus.xfer_rate == '0) ? AMMO_W'(1) : bus.xfer_rate;
    room      = (acc_q < bus.max_ammo) ? (bus.max_ammo - acc_q) : '0;
    chunk     = min3(rate_eff, room, depot_level);
    new_acc   = acc_q + chunk;
    new_depot = depot_level - chunk;
    xfer_go   = (state_q == ST_XFER) && !bus.fire_active;
    depot_wr  = bus.depot_load && (state_q != ST_XFER);
`ifdef AMMO_LOADER_AUTO_EN
    start     = bus.reload_req || ((bus.cur_ammo == '0) && !bus.fire_active);
`else
    start     = bus.reload_req;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CHECK;
      ST_CHECK: begin
        if (acc_q >= bus.max_ammo)   state_d = ST_DONE;
        else if (depot_level == '0)  state_d = ST_IDLE;
        else                         state_d = ST_XFER;
      end
      ST_XFER:  if (xfer_go && ((new_acc == bus.max_ammo) || (new_depot == '0)))
                  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      ammo_out_q <= '0;
      loading_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      loading_q <= xfer_go;
      if ((state_q == ST_IDLE) && start) begin
        acc_q <= bus.cur_ammo;
      end else if (xfer_go) begin
        acc_q <= new_acc;
      end
      if (xfer_go) begin
        ammo_out_q <= new_acc;
      end
    end
  end

  depot_counter #(.AMMO_W(AMMO_W)) u_depot (
    .clk      (clk),
    .rst      (rst),
    .load     (depot_wr),
    .load_val (bus.depot_in),
    .sub      (xfer_go),
    .sub_val  (chunk),
    .level    (depot_level)
  );

  assign bus.ammo_out    = ammo_out_q;
  assign bus.loading     = loading_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.depot_level = depot_level;
  assign bus.error       = (state_q == ST_CHECK) && (acc_q < bus.max_ammo) &&
                           (depot_level == '0);

endmodule

// File: doc/ammo_loader.md
AMMO_LOADER -- requirements
Module: ammo_loader

Interface
REQ-001 Parameter AMMO_W, default 9, width of every round-count bus.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 reload_req  input  1  level request to refill the weapon magazine.
REQ-005 fire_active  input  1  weapon is firing this cycle; transfer pauses.
REQ-006 cur_ammo  input  AMMO_W  weapon's current round count.
REQ-007 max_ammo  input  AMMO_W  weapon magazine capacity.
REQ-008 xfer_rate  input  AMMO_W  maximum rounds moved per transfer cycle.
REQ-009 depot_load  input  1  load depot_in into the depot level.
REQ-010 depot_in  input  AMMO_W  new depot stock value.
REQ-011 ammo_out  output  AMMO_W  round count driven to the weapon's ammo load bus.
REQ-012 loading  output  1  load strobe to the weapon; high only on transfer cycles.
REQ-013 busy  output  1  high in any state except IDLE.
REQ-014 done  output  1  one-cycle pulse on reload completion.
REQ-015 depot_level  output  AMMO_W  current depot stock.
REQ-016 error  output  1  one-cycle pulse when a reload starts with an empty depot.

Function
REQ-017 FSM states IDLE, CHECK, XFER, DONE, encoded in the shared package.
REQ-018 IDLE -> CHECK when reload_req=1; CHECK captures acc <= cur_ammo.
REQ-019 CHECK -> DONE with no transfer when acc >= max_ammo; done pulses.
REQ-020 CHECK -> IDLE with error pulse when depot_level=0 and acc < max_ammo.
REQ-021 CHECK -> XFER otherwise.
REQ-022 XFER per cycle with fire_active=0: chunk = min(rate_eff, max_ammo-acc, depot_level); acc += chunk; depot_level -= chunk; loading=1; ammo_out = new acc, registered, same edge.
REQ-023 rate_eff = xfer_rate, except xfer_rate=0 is treated as 1.
REQ-024 XFER with fire_active=1: no change to acc/depot, loading=0, state held.
REQ-025 XFER -> DONE when new acc = max_ammo or new depot_level = 0.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; a held reload_req restarts only after one IDLE cycle.
REQ-027 All arithmetic unsigned AMMO_W-bit; chunk selection guarantees no wrap of acc or depot_level.
REQ-028 depot_load in IDLE/CHECK/DONE overwrites depot_level; in XFER it is ignored.
REQ-029 max_ammo and xfer_rate are sampled each cycle; the weapon holds them stable during busy.

Reset
REQ-030 On rst: state=IDLE, acc=0, ammo_out=0, loading=0, busy=0, done=0, error=0, depot_level=0.
REQ-031 rst asserted mid-XFER aborts immediately; rounds already moved stay deducted.

Configuration
REQ-032 AMMO_LOADER_AUTO_EN defined: IDLE -> CHECK also when cur_ammo=0 and fire_active=0, with no reload_req.
REQ-033 AMMO_LOADER_AUTO_EN undefined: only reload_req starts a reload.

Structure
REQ-034 Package weapons_pkg holds AMMO_W default, the loader state enum and the attack-mode code 4'b0010.
REQ-035 One sub-module, depot_counter: AMMO_W register with load, subtract-chunk and async reset; FSM and chunk logic stay in ammo_loader.

Verification
REQ-036 depot=300, cur=0, max=100, rate=30, reload_req -> loading cycles give ammo_out 30,60,90,100; depot 200; done pulse.
REQ-037 depot=20, cur=0, max=100, rate=30 -> single chunk, ammo_out=20, depot=0, done pulse; next reload -> error pulse, no loading.
REQ-038 cur=100, max=100, reload_req -> done pulse, loading never high, depot unchanged.
REQ-039 fire_active=1 for 3 cycles mid-XFER -> loading=0 and ammo_out frozen those cycles, then resumes at the same value.
REQ-040 rst pulsed during XFER after first chunk -> all outputs zero asynchronously, state IDLE.
REQ-041 With AMMO_LOADER_AUTO_EN, cur=0, depot=50, max=40, no reload_req -> reload completes at ammo_out=40, depot=10.
